// File: rtl/pip_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// forwarding select codes and the forwarding decision helper.
package pip_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } pip_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    // The younger producer (EX/MEM) wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic       rs_read,
        input logic [4:0] rs_ad,
        input logic       mem_en,
        input logic [4:0] mem_ad,
        input logic       wb_en,
        input logic [4:0] wb_ad
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs_read && rs_ad != REG_X0) begin
            if (mem_en && mem_ad == rs_ad)
                sel = FWD_MEM;
            else if (wb_en && wb_ad == rs_ad)
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pip_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decoded stage fields in,
// register enables/discards, PC control and forwarding selects out.
// Handshake: none; all signals are level-sampled on the rising clk edge.
interface pip_hazard_ctrl_if;
    logic [4:0] id_rs1_ad, id_rs2_ad;
    logic       id_rs1_read, id_rs2_read;
    logic [4:0] ex_rs1_ad, ex_rs2_ad;
    logic       ex_rs1_read, ex_rs2_read;
    logic [4:0] ex_rd_ad;
    logic       ex_rdEn, ex_DMread;
    logic       ex_branch_comm, ex_branch_taken, ex_branch_res;
    logic [4:0] mem_rd_ad;
    logic       mem_rdEn;
    logic [4:0] wb_rd_ad;
    logic       wb_rdEn;
    logic       mem_dm_req, dm_ready;

    logic       pc_en, redirect;
    logic       if_id_en, if_id_discard;
    logic       id_ex_en, id_ex_discard;
    logic       ex_mem_en, mem_wb_en;
    logic [1:0] fwd1_sel, fwd2_sel;

    modport master (
        output id_rs1_ad, id_rs2_ad, id_rs1_read, id_rs2_read,
               ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read,
               ex_rd_ad, ex_rdEn, ex_DMread,
               ex_branch_comm, ex_branch_taken, ex_branch_res,
               mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn, mem_dm_req, dm_ready,
        input  pc_en, redirect, if_id_en, if_id_discard, id_ex_en, id_ex_discard,
               ex_mem_en, mem_wb_en, fwd1_sel, fwd2_sel
    );

    modport slave (
        input  id_rs1_ad, id_rs2_ad, id_rs1_read, id_rs2_read,
               ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read,
               ex_rd_ad, ex_rdEn, ex_DMread,
               ex_branch_comm, ex_branch_taken, ex_branch_res,
               mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn, mem_dm_req, dm_ready,
        output pc_en, redirect, if_id_en, if_id_discard, id_ex_en, id_ex_discard,
               ex_mem_en, mem_wb_en, fwd1_sel, fwd2_sel
    );
endinterface

// File: rtl/pip_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (inc && count != {W{1'b1}})
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pip_hazard_ctrl.sv
// Hazard and flow controller for the 5-stage pipeline: stage enables/discards,
// PC enable, redirect strobe, EX forwarding selects and stall/flush counters.
module pip_hazard_ctrl
    import pip_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             perf_clr,
    pip_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output pip_state_e       fsm_state
);
    pip_state_e state, state_nx;
    logic lu, mp, mw;
    logic pc_en, redirect, if_id_en, if_id_discard, id_ex_en, id_ex_discard;
    logic ex_mem_en, mem_wb_en;

    assign lu = hz.ex_DMread && hz.ex_rd_ad != REG_X0 &&
                ((hz.id_rs1_read && hz.id_rs1_ad == hz.ex_rd_ad) ||
                 (hz.id_rs2_read && hz.id_rs2_ad == hz.ex_rd_ad));
    assign mp = hz.ex_branch_comm && (hz.ex_branch_taken != hz.ex_branch_res);
    assign mw = hz.mem_dm_req && !hz.dm_ready;

    always_comb begin
        state_nx      = state;
        pc_en         = 1'b1;
        redirect      = 1'b0;
        if_id_en      = 1'b1;
        if_id_discard = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_discard = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        // Held reset shows the INIT bubble-fill values regardless of the register.
        if (!rst_n || state == ST_INIT) begin
            pc_en         = 1'b0;
            if_id_discard = 1'b1;
            id_ex_discard = 1'b1;
            state_nx      = ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_FLUSH: begin
                    if (mw) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                        state_nx  = ST_MEMWAIT;
                    end else begin
                        if (mp) begin
                            redirect      = 1'b1;
                            if_id_discard = 1'b1;
                            id_ex_discard = 1'b1;
                            state_nx      = ST_FLUSH;
                        end else begin
                            if (lu) begin
                                pc_en         = 1'b0;
                                if_id_en      = 1'b0;
                                id_ex_discard = 1'b1;
                            end
                            state_nx = ST_RUN;
                        end
                        // Instruction memory is synchronous: the fetch after a redirect is stale.
                        if (state == ST_FLUSH)
                            if_id_discard = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    if (!hz.dm_ready) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        mem_wb_en = 1'b0;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                default: state_nx = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_INIT;
        else
            state <= state_nx;
    end

    assign fsm_state        = state;
    assign hz.pc_en         = pc_en;
    assign hz.redirect      = redirect;
    assign hz.if_id_en      = if_id_en;
    assign hz.if_id_discard = if_id_discard;
    assign hz.id_ex_en      = id_ex_en;
    assign hz.id_ex_discard = id_ex_discard;
    assign hz.ex_mem_en     = ex_mem_en;
    assign hz.mem_wb_en     = mem_wb_en;

    assign hz.fwd1_sel = fwd_select(hz.ex_rs1_read, hz.ex_rs1_ad, hz.mem_rdEn, hz.mem_rd_ad,
                                    hz.wb_rdEn, hz.wb_rd_ad);
    assign hz.fwd2_sel = fwd_select(hz.ex_rs2_read, hz.ex_rs2_ad, hz.mem_rdEn, hz.mem_rd_ad,
                                    hz.wb_rdEn, hz.wb_rd_ad);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (!pc_en && state != ST_INIT),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (redirect),
        .count (flush_count)
    );
endmodule

// File: doc/pip_hazard_ctrl.md
# pip_hazard_ctrl

Pipeline hazard and flow controller for the 5-stage pipelined RISC-V core. It is the producer of the `pip_en`/`discard` pair consumed by every inter-stage pipeline register. It also drives the PC enable, the redirect strobe and the EX-stage forwarding selects. Inputs are the decoded register addresses and control bits already carried in the ID, EX, MEM and WB stages. It sits beside the pipeline registers, and its only state is a small FSM plus two saturating performance counters.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `id_rs1_ad`, `id_rs2_ad` in 5 each: source addresses of the instruction in ID.
- `id_rs1_read`, `id_rs2_read` in 1 each: the ID instruction reads rs1 or rs2.
- `ex_rs1_ad`, `ex_rs2_ad`, `ex_rs1_read`, `ex_rs2_read` in 5/5/1/1: the same fields held in the ID/EX register.
- `ex_rd_ad`, `ex_rdEn`, `ex_DMread` in 5/1/1: EX destination, write enable, and load flag.
- `ex_branch_comm`, `ex_branch_taken`, `ex_branch_res` in 1 each: EX holds a branch, its predicted direction, and its resolved direction.
- `mem_rd_ad`, `mem_rdEn` in 5/1: EX/MEM destination and write enable.
- `wb_rd_ad`, `wb_rdEn` in 5/1: MEM/WB destination and write enable.
- `mem_dm_req`, `dm_ready` in 1 each: MEM stage is accessing data memory; data memory completes the access this cycle.
- `perf_clr` in 1: synchronously clears both counters.
- `pc_en` out 1: PC update enable.
- `redirect` out 1: load PC from the branch-resolution target.
- `if_id_en`, `if_id_discard` out 1 each: enable and discard for the IF/ID register.
- `id_ex_en`, `id_ex_discard` out 1 each: enable and discard for the ID/EX register.
- `ex_mem_en`, `mem_wb_en` out 1 each: enables for the EX/MEM and MEM/WB registers.
- `fwd1_sel`, `fwd2_sel` out 2 each: EX operand source select. 0 = register file, 1 = EX/MEM, 2 = MEM/WB.
- `stall_cycles`, `flush_count` out CNT_W each: performance counters.

## Operation
- The FSM has four states: INIT, RUN, MEMWAIT and FLUSH. The reset state is INIT.
- INIT (one cycle after reset release):
  - pc_en=0, redirect=0.
  - All stage enables are 1, and if_id_discard and id_ex_discard are 1, which fills the pipeline with bubbles.
  - Next state is RUN.
- Hazard terms:
  - Load-use hazard (lu): ex_DMread & ex_rd_ad≠0 & ((id_rs1_read & id_rs1_ad==ex_rd_ad) | (id_rs2_read & id_rs2_ad==ex_rd_ad)).
  - Mispredict (mp): ex_branch_comm & (ex_branch_taken ≠ ex_branch_res).
  - Memory wait (mw): mem_dm_req & !dm_ready.
- RUN and FLUSH resolve hazards in priority order: mw, then mp, then lu.
  - mw: all enables are 0 and all discards are 0, freezing the whole pipeline. Next state is MEMWAIT.
  - mp: redirect=1, pc_en=1, all enables are 1, and if_id_discard=id_ex_discard=1. Next state is FLUSH.
  - lu: pc_en=0 and if_id_en=0 (ID is held). id_ex_en=1 with id_ex_discard=1 (bubble). EX/MEM and MEM/WB are enabled. Next state is RUN.
  - No hazard: all enables are 1 and all discards are 0.
  - In FLUSH, if_id_discard is additionally forced to 1 to cover the synchronous instruction-memory latency. With no hazard, FLUSH goes to RUN.
- MEMWAIT: the pipeline stays frozen while dm_ready=0. lu and mp are not evaluated. When dm_ready=1, the outputs are the RUN no-hazard values with all enables at 1, and the next state is RUN. Hazards are re-evaluated on the following cycle.
- Forwarding is combinational and independent of the FSM, shown here for operand 1 (operand 2 is identical on rs2):
  - fwd1_sel=1 when ex_rs1_read & mem_rdEn & mem_rd_ad==ex_rs1_ad≠0.
  - Otherwise fwd1_sel=2 when ex_rs1_read & wb_rdEn & wb_rd_ad==ex_rs1_ad≠0.
  - Otherwise fwd1_sel=0. EX/MEM wins over MEM/WB, and x0 is never forwarded.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0 outside INIT.
  - flush_count increments on every cycle with redirect=1.
  - Both saturate at 2^CNT_W−1. perf_clr takes precedence over increment.

## Timing
- All outputs except the forwarding selects are Moore/Mealy combinational from state and current inputs, so they take effect at the next clk edge of the pipeline registers.
- Reset values: state=INIT, stall_cycles=0, flush_count=0. While rst_n=0, the outputs take their INIT values.
- A load-use stall lasts exactly one cycle.
- A mispredict costs two bubble cycles: the redirect cycle plus the FLUSH cycle.
- A memory wait lasts for as long as dm_ready=0.
- Simultaneous mw and mp: mw wins. mp is re-detected after the wait because EX was frozen.
- rst_n asserted during MEMWAIT or FLUSH aborts the state and goes to INIT on the next edge.

## Structure
- A shared pipeline package holds the FSM state enum, the FWD_RF/FWD_MEM/FWD_WB constants (0/1/2), and the x0 address constant.
- One sub-module, `sat_counter` (parameter W; inputs clr, inc), is instantiated twice.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: one INIT cycle with pc_en=0 and both discards=1, then RUN with all enables=1; counters read 0.
- Load-use: ex_DMread=1, ex_rd_ad=5, id_rs2_read=1, id_rs2_ad=5. Required: one cycle with pc_en=0, if_id_en=0, id_ex_discard=1; then normal flow; stall_cycles=1.
- Mispredict: ex_branch_comm=1, taken=1, res=0. Required: redirect=1 with both discards=1; next cycle if_id_discard=1 only; flush_count=1.
- Memory wait: mem_dm_req=1 with dm_ready=0 for 4 cycles while a mispredict is present. Required: all enables=0 for 4 cycles with redirect=0, then the mispredict is handled; stall_cycles=4.
- Forwarding: mem_rd_ad=wb_rd_ad=ex_rs1_ad=7 with both write enables=1 → fwd1_sel=1. Set ex_rs1_ad=0 → fwd1_sel=0.
- Saturation: with CNT_W=4, run 20 lu cycles → stall_cycles=15. Pulse perf_clr → 0.
